// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared state constants, decision word width, FSM encoding and predecessor select
package viterbi_pkg;
  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam int DEC_W = 8;
  typedef enum logic [1:0] {FILL, TRACE, OUTPUT} tb_state_e;
  // decision word layout is {p11,p01,p10,p00}
  function automatic logic [1:0] pred_sel(logic [DEC_W-1:0] w, logic [1:0] st);
    return st == ST_00 ? w[1:0] : st == ST_10 ? w[3:2] : st == ST_01 ? w[5:4] : w[7:6];
  endfunction
endpackage

// File: rtl/survivor_mem.sv
// survivor_mem: frame-deep decision register file, sync write, combinational read, async clear
module survivor_mem
  import viterbi_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DEC_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [DEC_W-1:0] rdata
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DEC_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr[IW-1:0]] <= wdata;
    end
  end
  assign rdata = mem_q[raddr[IW-1:0]];
endmodule

// File: rtl/viterbi_traceback.sv
// viterbi_traceback: K=3 4-state survivor traceback, one frame at a time, serial in-order output.
// Define VITERBI_TB_FRAME_OUT_EN to add the parallel o_frame / o_frame_valid outputs.
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int PTR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_tb,
  input  logic [1:0]           i_prv_st_00,
  input  logic [1:0]           i_prv_st_10,
  input  logic [1:0]           i_prv_st_01,
  input  logic [1:0]           i_prv_st_11,
  input  logic [1:0]           i_select_node,
  output logic                 o_ready,
  output logic                 o_bit,
  output logic                 o_valid,
  output logic                 o_last,
`ifdef VITERBI_TB_FRAME_OUT_EN
  output logic [FRAME_LEN-1:0] o_frame,
  output logic                 o_frame_valid,
`endif
  output logic                 o_overflow
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(FRAME_LEN - 1);
  tb_state_e state_q, state_d;
  logic [PTR_W-1:0] wr_cnt_q, wr_cnt_d, rd_idx_q, rd_idx_d, out_cnt_q, out_cnt_d;
  logic [1:0] cur_st_q, cur_st_d;
  logic [FRAME_LEN-1:0] bits_q, bits_d;
  logic o_bit_q, o_bit_d, o_valid_q, o_valid_d, o_last_q, o_last_d, ovf_q, ovf_d;
  logic [DEC_W-1:0] rd_word;
  logic accept, sel_bit;
  assign o_ready = state_q == FILL;
  assign accept = en_tb && o_ready;
  survivor_mem #(.DEPTH(FRAME_LEN), .AW(PTR_W)) u_mem (
    .clk(clk), .rst(rst), .we(accept), .waddr(wr_cnt_q),
    .wdata({i_prv_st_11, i_prv_st_01, i_prv_st_10, i_prv_st_00}),
    .raddr(rd_idx_q), .rdata(rd_word)
  );
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) if (out_cnt_q == PTR_W'(i)) sel_bit = bits_q[i];
  end
  always_comb begin
    state_d = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_idx_d = rd_idx_q;
    out_cnt_d = out_cnt_q;
    cur_st_d = cur_st_q;
    bits_d = bits_q;
    o_bit_d = o_bit_q;
    o_valid_d = 1'b0;
    o_last_d = 1'b0;
    ovf_d = ovf_q | (en_tb & ~o_ready);
    case (state_q)
      FILL: if (accept) begin
        wr_cnt_d = wr_cnt_q == LAST ? '0 : wr_cnt_q + 1'b1;
        if (wr_cnt_q == LAST) begin
          cur_st_d = i_select_node;
          rd_idx_d = LAST;
          state_d = TRACE;
        end
      end
      TRACE: begin
        for (int i = 0; i < FRAME_LEN; i++) if (rd_idx_q == PTR_W'(i)) bits_d[i] = cur_st_q[1];
        cur_st_d = pred_sel(rd_word, cur_st_q);
        rd_idx_d = rd_idx_q == '0 ? '0 : rd_idx_q - 1'b1;
        out_cnt_d = '0;
        state_d = rd_idx_q == '0 ? OUTPUT : TRACE;
      end
      OUTPUT: begin
        // the cycle after the last bit is spent dropping o_valid before FILL reopens
        state_d = o_last_q ? FILL : OUTPUT;
        o_valid_d = ~o_last_q;
        o_bit_d = o_last_q ? o_bit_q : sel_bit;
        o_last_d = ~o_last_q && out_cnt_q == LAST;
        out_cnt_d = (o_last_q || out_cnt_q == LAST) ? '0 : out_cnt_q + 1'b1;
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      wr_cnt_q <= '0;
      rd_idx_q <= '0;
      out_cnt_q <= '0;
      cur_st_q <= '0;
      bits_q <= '0;
      o_bit_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_last_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_idx_q <= rd_idx_d;
      out_cnt_q <= out_cnt_d;
      cur_st_q <= cur_st_d;
      bits_q <= bits_d;
      o_bit_q <= o_bit_d;
      o_valid_q <= o_valid_d;
      o_last_q <= o_last_d;
      ovf_q <= ovf_d;
    end
  end
  assign o_bit = o_bit_q;
  assign o_valid = o_valid_q;
  assign o_last = o_last_q;
  assign o_overflow = ovf_q;
`ifdef VITERBI_TB_FRAME_OUT_EN
  logic [FRAME_LEN-1:0] o_frame_q, o_frame_d;
  logic o_frame_valid_q, o_frame_valid_d;
  always_comb begin
    o_frame_d = (state_q == TRACE && rd_idx_q == '0) ? bits_d : o_frame_q;
    o_frame_valid_d = state_q == OUTPUT && !o_last_q && out_cnt_q == '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_frame_q <= '0;
      o_frame_valid_q <= 1'b0;
    end else begin
      o_frame_q <= o_frame_d;
      o_frame_valid_q <= o_frame_valid_d;
    end
  end
  assign o_frame = o_frame_q;
  assign o_frame_valid = o_frame_valid_q;
`endif
endmodule

// File: tb/tb_viterbi_traceback.sv
// tb_viterbi_traceback: directed frame table plus gap, overflow and mid-output reset sequences
module tb_viterbi_traceback;
  logic clk = 1'b0, rst = 1'b1, en_tb = 1'b0;
  logic [1:0] p00 = '0, p10 = '0, p01 = '0, p11 = '0, sel = '0;
  logic o_ready, o_bit, o_valid, o_last, o_overflow;
`ifdef VITERBI_TB_FRAME_OUT_EN
  logic [7:0] o_frame;
  logic o_frame_valid;
`endif
  int total = 0, bad = 0;
  typedef struct {
    logic [7:0][1:0] p00, p10, p01, p11;
    logic [1:0] sel;
    logic [7:0] exp;
  } frame_t;
  frame_t tbl[4];

  viterbi_traceback #(.FRAME_LEN(8), .PTR_W(4)) dut (
    .clk(clk), .rst(rst), .en_tb(en_tb),
    .i_prv_st_00(p00), .i_prv_st_10(p10), .i_prv_st_01(p01), .i_prv_st_11(p11),
    .i_select_node(sel), .o_ready(o_ready), .o_bit(o_bit), .o_valid(o_valid),
    .o_last(o_last),
`ifdef VITERBI_TB_FRAME_OUT_EN
    .o_frame(o_frame), .o_frame_valid(o_frame_valid),
`endif
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic feed(int f, bit gaps, bit hold);
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        en_tb = 1'b0;
        @(posedge clk); #1;
      end
      if (k == 0) chk("ready_fill", o_ready, 1);
      p00 = tbl[f].p00[k];
      p10 = tbl[f].p10[k];
      p01 = tbl[f].p01[k];
      p11 = tbl[f].p11[k];
      sel = tbl[f].sel;
      en_tb = 1'b1;
      @(posedge clk); #1;
    end
    if (!hold) en_tb = 1'b0;
  endtask

  task automatic collect(int f, int rst_after);
    logic [7:0] got = '0;
    int n = 0, cyc = 0;
    while (n < 8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk("ready_drop", o_ready, 0);
      if (o_valid) begin
        if (n == 0) chk("latency", cyc, 9);
        got[n] = o_bit;
        chk("last", o_last, n == 7);
        n++;
        if (n == rst_after) begin
          en_tb = 1'b0;
          rst = 1'b1;
          #1;
          chk("rst_valid", o_valid, 0);
          chk("rst_ready", o_ready, 1);
          chk("rst_ovf", o_overflow, 0);
          rst = 1'b0;
          return;
        end
      end
    end
    en_tb = 1'b0;
    chk("count", n, 8);
    chk("bits", got, tbl[f].exp);
    chk("ready_hold", o_ready, 0);
    @(posedge clk); #1;
    chk("valid_end", o_valid, 0);
    chk("last_end", o_last, 0);
    chk("ready_back", o_ready, 1);
    chk("turnaround", cyc + 1, 17);
  endtask

  initial begin
    tbl[0].p00 = '0; tbl[0].p10 = '0; tbl[0].p01 = {8{2'b10}}; tbl[0].p11 = {8{2'b10}};
    tbl[0].sel = 2'b00; tbl[0].exp = 8'h00;
    tbl[1].p00 = '0; tbl[1].p10 = '0; tbl[1].p01 = {8{2'b10}}; tbl[1].p11 = {8{2'b11}};
    tbl[1].sel = 2'b11; tbl[1].exp = 8'hff;
    tbl[2] = tbl[1];
    tbl[2].sel = 2'b10; tbl[2].exp = 8'h80;
    // encoder path for input bits 1,0,1,1,0,0,1,0 with misleading off-path fields
    tbl[3].p00 = {2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01};
    tbl[3].p10 = {2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    tbl[3].p01 = {2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11};
    tbl[3].p11 = {2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    tbl[3].sel = 2'b01; tbl[3].exp = 8'b0100_1101;
    #12;
    chk("rst_ready0", o_ready, 1);
    chk("rst_valid0", o_valid, 0);
    chk("rst_bit0", o_bit, 0);
    chk("rst_last0", o_last, 0);
    chk("rst_ovf0", o_overflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int f = 0; f < 4; f++) begin
      feed(f, 0, 0);
      collect(f, 0);
    end
    feed(3, 1, 0);
    collect(3, 0);
    chk("no_ovf", o_overflow, 0);
    feed(2, 0, 1);
    collect(2, 0);
    chk("ovf_set", o_overflow, 1);
    feed(3, 0, 0);
    collect(3, 0);
    chk("ovf_sticky", o_overflow, 1);
    feed(1, 0, 0);
    collect(1, 3);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", o_valid, 0);
    end
    feed(2, 0, 0);
    collect(2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
